// File: rtl/nn_phase_sequencer_pkg.sv
// Shared definitions for the NN phase sequencer: phase codes and default sizes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nn_phase_sequencer_pkg;

    // Phase codes as seen on the phase output.
    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_FWD  = 3'd1,
        PH_SIG  = 3'd2,
        PH_UPD  = 3'd3,
        PH_DONE = 3'd4
    } phase_t;

    // Default network geometry: 784 inputs (28x28 image), 40 hidden neurons.
    localparam int N_IN_DEF   = 784;
    localparam int N_HID_DEF  = 40;
    localparam int IN_AW_DEF  = 10;
    localparam int NEU_AW_DEF = 6;
    localparam int W_AW_DEF   = 15;

    // Counter width must hold both the input index and the neuron index,
    // because the counter swaps roles between FWD and UPD.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nn_idx_counter.sv
// Two-level nested index counter with a stride address accumulator.
// Latency: next-value outputs are combinational from clr/step; state updates on the next clk edge.
// Backpressure: holds its position whenever step and clr are both low.
//
// Ports:
//   clk, rst               clock, synchronous active-low reset
//   swap                   0: inner=input (limit N_IN), stride 1      (FWD order)
//                          1: inner=neuron (limit N_HID), stride N_IN (UPD order)
//   clr                    return to (0,0), address 0
//   step                   advance one position
//   inner_last/outer_last  current position is at the inner/outer limit
//   nxt_inner/nxt_outer    position the counter will hold after this edge
//   nxt_addr               address that goes with nxt_inner/nxt_outer
module nn_idx_counter
    import nn_phase_sequencer_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_HID = N_HID_DEF,
    parameter int CW    = max2(IN_AW_DEF, NEU_AW_DEF),
    parameter int AW    = W_AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          swap,
    input  logic          clr,
    input  logic          step,
    output logic          inner_last,
    output logic          outer_last,
    output logic [CW-1:0] nxt_inner,
    output logic [CW-1:0] nxt_outer,
    output logic [AW-1:0] nxt_addr
);

    logic [CW-1:0] inner_q;
    logic [CW-1:0] outer_q;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] inner_max;
    logic [CW-1:0] outer_max;
    logic [AW-1:0] stride;

    always_comb begin
        inner_max = swap ? CW'(N_HID - 1) : CW'(N_IN - 1);
        outer_max = swap ? CW'(N_IN - 1)  : CW'(N_HID - 1);
        stride    = swap ? AW'(N_IN)      : AW'(1);
    end

    assign inner_last = (inner_q == inner_max);
    assign outer_last = (outer_q == outer_max);

    // Address is tracked by addition only. In FWD order the address simply
    // counts up. In UPD order it steps by N_IN per neuron, and on a neuron
    // wrap it restarts at the next input index (neuron 0, input i+1).
    always_comb begin
        nxt_inner = inner_q;
        nxt_outer = outer_q;
        nxt_addr  = addr_q;
        if (clr) begin
            nxt_inner = '0;
            nxt_outer = '0;
            nxt_addr  = '0;
        end else if (step) begin
            if (!inner_last) begin
                nxt_inner = inner_q + 1'b1;
                nxt_addr  = addr_q + stride;
            end else if (!outer_last) begin
                nxt_inner = '0;
                nxt_outer = outer_q + 1'b1;
                nxt_addr  = swap ? (AW'(outer_q) + 1'b1) : (addr_q + 1'b1);
            end else begin
                nxt_inner = '0;
                nxt_outer = '0;
                nxt_addr  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inner_q <= '0;
            outer_q <= '0;
            addr_q  <= '0;
        end else begin
            inner_q <= nxt_inner;
            outer_q <= nxt_outer;
            addr_q  <= nxt_addr;
        end
    end

endmodule

// File: rtl/nn_phase_sequencer.sv
// Training-pass controller: sequences FWD (MAC), SIG (sigmoid), UPD (weight update), then pulses done.
// Latency: start sampled at edge t gives first mac_en in cycle t+1; unstalled done at t+1+2*N_IN*N_HID+N_HID.
// Backpressure: stall freezes state, counters and addresses and zeroes strobes; abort returns to IDLE.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   start             begin a pass (taken only in IDLE)
//   abort             cancel the pass (wins over stall and start)
//   stall             hold sequencing this cycle
//   busy              high in FWD/SIG/UPD
//   done              one-cycle pulse in DONE
//   phase             current phase code
//   in_addr           input index
//   w_addr            weight address = neuron*N_IN + input
//   neuron_idx        neuron index (FWD/UPD) or sigmoid index (SIG)
//   mac_clr/mac_en    accumulator clear / accumulate
//   z_wr              store accumulator as z[neuron_idx]
//   sig_en            compute sigmoid(z[neuron_idx])
//   upd_en            write updated weight at w_addr
module nn_phase_sequencer
    import nn_phase_sequencer_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int N_HID  = N_HID_DEF,
    parameter int IN_AW  = IN_AW_DEF,
    parameter int NEU_AW = NEU_AW_DEF,
    parameter int W_AW   = W_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic [2:0]        phase,
    output logic [IN_AW-1:0]  in_addr,
    output logic [W_AW-1:0]   w_addr,
    output logic [NEU_AW-1:0] neuron_idx,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              z_wr,
    output logic              sig_en,
    output logic              upd_en
);

    localparam int CW = max2(IN_AW, NEU_AW);

    phase_t state_q;
    phase_t state_d;

    logic            cnt_clr;
    logic            cnt_step;
    logic            cnt_swap;
    logic            in_last;
    logic            out_last;
    logic [CW-1:0]   nxt_inner;
    logic [CW-1:0]   nxt_outer;
    logic [W_AW-1:0] nxt_addr;

    logic              mac_en_d;
    logic              mac_clr_d;
    logic              z_wr_d;
    logic              sig_en_d;
    logic              upd_en_d;
    logic              done_d;
    logic [IN_AW-1:0]  in_addr_d;
    logic [NEU_AW-1:0] neuron_d;
    logic [W_AW-1:0]   w_addr_d;

    // One counter serves all three busy phases. FWD runs it input-inner;
    // SIG and UPD run it neuron-inner (SIG only uses the inner index as k).
    assign cnt_swap = (state_q != PH_FWD);

    nn_idx_counter #(
        .N_IN  (N_IN),
        .N_HID (N_HID),
        .CW    (CW),
        .AW    (W_AW)
    ) u_idx (
        .clk        (clk),
        .rst        (rst),
        .swap       (cnt_swap),
        .clr        (cnt_clr),
        .step       (cnt_step),
        .inner_last (in_last),
        .outer_last (out_last),
        .nxt_inner  (nxt_inner),
        .nxt_outer  (nxt_outer),
        .nxt_addr   (nxt_addr)
    );

    // State and counter reflect the item currently on the outputs. Each
    // unstalled edge moves to the next item and raises its strobe, so every
    // item is strobed exactly once no matter how long a stall lasts.
    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_step = 1'b0;
        mac_en_d = 1'b0;
        sig_en_d = 1'b0;
        upd_en_d = 1'b0;
        done_d   = 1'b0;
        if (abort) begin
            state_d = PH_IDLE;
            cnt_clr = 1'b1;
        end else if (!stall) begin
            unique case (state_q)
                PH_IDLE: begin
                    if (start) begin
                        state_d  = PH_FWD;
                        cnt_clr  = 1'b1;
                        mac_en_d = 1'b1;
                    end
                end
                PH_FWD: begin
                    if (in_last && out_last) begin
                        state_d  = PH_SIG;
                        cnt_clr  = 1'b1;
                        sig_en_d = 1'b1;
                    end else begin
                        cnt_step = 1'b1;
                        mac_en_d = 1'b1;
                    end
                end
                PH_SIG: begin
                    if (in_last) begin
                        state_d  = PH_UPD;
                        cnt_clr  = 1'b1;
                        upd_en_d = 1'b1;
                    end else begin
                        cnt_step = 1'b1;
                        sig_en_d = 1'b1;
                    end
                end
                PH_UPD: begin
                    if (in_last && out_last) begin
                        state_d = PH_DONE;
                        cnt_clr = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        cnt_step = 1'b1;
                        upd_en_d = 1'b1;
                    end
                end
                PH_DONE: begin
                    // start here is deliberately not looked at
                    state_d = PH_IDLE;
                end
                default: begin
                    state_d = PH_IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // Output mapping from the counter's next position. Kept apart from the
    // block above because it depends on the counter, which depends on that
    // block's clr/step decisions.
    always_comb begin
        mac_clr_d = mac_en_d && (nxt_inner == '0);
        z_wr_d    = mac_en_d && (nxt_inner == CW'(N_IN - 1));
        in_addr_d = '0;
        neuron_d  = '0;
        w_addr_d  = '0;
        unique case (state_d)
            PH_FWD: begin
                in_addr_d = IN_AW'(nxt_inner);
                neuron_d  = NEU_AW'(nxt_outer);
                w_addr_d  = nxt_addr;
            end
            PH_SIG: begin
                neuron_d  = NEU_AW'(nxt_inner);
            end
            PH_UPD: begin
                in_addr_d = IN_AW'(nxt_outer);
                neuron_d  = NEU_AW'(nxt_inner);
                w_addr_d  = nxt_addr;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= PH_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            in_addr    <= '0;
            neuron_idx <= '0;
            w_addr     <= '0;
            mac_clr    <= 1'b0;
            mac_en     <= 1'b0;
            z_wr       <= 1'b0;
            sig_en     <= 1'b0;
            upd_en     <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy       <= (state_d == PH_FWD) || (state_d == PH_SIG) || (state_d == PH_UPD);
            done       <= done_d;
            in_addr    <= in_addr_d;
            neuron_idx <= neuron_d;
            w_addr     <= w_addr_d;
            mac_clr    <= mac_clr_d;
            mac_en     <= mac_en_d;
            z_wr       <= z_wr_d;
            sig_en     <= sig_en_d;
            upd_en     <= upd_en_d;
        end
    end

    assign phase = state_q;

endmodule
